// File: rtl/bus_arbiter.sv
// Two-requester (CPU = 0, DMA = 1) round-robin memory bus arbiter
// with a read-modify-write lock and a bounded wait for mem_ready.
module bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_we,
    input  logic [1:0]  req_lock,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [7:0]  rdata,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_data_in,
    output logic        mem_read_en,
    output logic        mem_valid,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [7:0]  mem_data_out_q, mem_data_out_d;
    logic        mem_read_en_q, mem_read_en_d;
    logic        mem_valid_q, mem_valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        lock_q, lock_d;
    logic        lock_held_q, lock_held_d;
    logic        last_owner_q, last_owner_d;

    logic        win_valid;
    logic        win_id;
    logic [1:0]  owner_oh;

    assign owner_oh = owner_q ? 2'b10 : 2'b01;

    // A held lock narrows the candidate set to the previous owner.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 1'b0;
        if (lock_held_q) begin
            win_valid = req[last_owner_q];
            win_id    = last_owner_q;
        end else begin
            unique case (req)
                2'b01: begin
                    win_valid = 1'b1;
                    win_id    = 1'b0;
                end
                2'b10: begin
                    win_valid = 1'b1;
                    win_id    = 1'b1;
                end
                2'b11: begin
                    win_valid = 1'b1;
                    win_id    = ~last_owner_q;
                end
                default: begin
                    win_valid = 1'b0;
                    win_id    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        done_d         = 2'b00;
        err_d          = 2'b00;
        rdata_d        = rdata_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        mem_read_en_d  = mem_read_en_q;
        mem_valid_d    = mem_valid_q;
        cnt_d          = cnt_q;
        owner_d        = owner_q;
        we_d           = we_q;
        lock_d         = lock_q;
        lock_held_d    = lock_held_q;
        last_owner_d   = last_owner_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d        = ACCESS;
                    gnt_d          = win_id ? 2'b10 : 2'b01;
                    owner_d        = win_id;
                    we_d           = req_we[win_id];
                    lock_d         = req_lock[win_id];
                    mem_address_d  = win_id ? addr1 : addr0;
                    mem_data_out_d = win_id ? wdata1 : wdata0;
                    mem_read_en_d  = ~req_we[win_id];
                    mem_valid_d    = 1'b1;
                    cnt_d          = 8'd0;
                end
            end
            ACCESS: begin
                // A ready on the timeout cycle still counts as success.
                if (mem_ready || (cnt_q == TIMEOUT_C)) begin
                    state_d       = DONE;
                    done_d        = owner_oh;
                    err_d         = mem_ready ? 2'b00 : owner_oh;
                    mem_valid_d   = 1'b0;
                    mem_read_en_d = 1'b1;
                    if (!mem_ready) begin
                        rdata_d = 8'hFF;
                    end else if (!we_q) begin
                        rdata_d = mem_data_in;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d      = IDLE;
                gnt_d        = 2'b00;
                last_owner_d = owner_q;
                lock_held_d  = lock_q & ~(|err_q);
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q        <= IDLE;
            gnt_q          <= 2'b00;
            done_q         <= 2'b00;
            err_q          <= 2'b00;
            rdata_q        <= 8'h00;
            mem_address_q  <= 16'h0000;
            mem_data_out_q <= 8'h00;
            mem_read_en_q  <= 1'b1;
            mem_valid_q    <= 1'b0;
            cnt_q          <= 8'd0;
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            lock_q         <= 1'b0;
            lock_held_q    <= 1'b0;
            last_owner_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            done_q         <= done_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_valid_q    <= mem_valid_d;
            cnt_q          <= cnt_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            lock_q         <= lock_d;
            lock_held_q    <= lock_held_d;
            last_owner_q   <= last_owner_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_valid    = mem_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter against a transaction-level model,
// plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;

    localparam int TO = 15;

    logic        ph1;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        mem_read_en;
    logic        mem_valid;
    logic        mem_ready;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .ph1          (ph1),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_read_en  (mem_read_en),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    int cyc = 0;

    // Model: a transaction is either absent, in flight (age counts
    // waited cycles), or in its completion cycle.
    bit          m_busy, m_fin, m_last, m_lockh, m_we, m_lk;
    int          m_age, m_own;
    logic [1:0]  e_gnt, e_done, e_err;
    logic [7:0]  e_rdata, e_wd;
    logic [15:0] e_addr;
    logic        e_rden, e_valid;

    task automatic model_step();
        logic [1:0] cand;
        int w;
        if (reset) begin
            m_busy = 0; m_fin = 0; m_age = 0; m_own = 0;
            m_last = 1; m_lockh = 0; m_we = 0; m_lk = 0;
            e_gnt = 0; e_done = 0; e_err = 0; e_rdata = 0;
            e_addr = 0; e_wd = 0; e_rden = 1; e_valid = 0;
        end else if (m_fin) begin
            m_last  = (m_own == 1);
            m_lockh = m_lk && (e_err == 2'b00);
            m_fin = 0; m_busy = 0;
            e_gnt = 0; e_done = 0; e_err = 0;
        end else if (m_busy) begin
            if (mem_ready || m_age == TO) begin
                m_fin   = 1;
                e_done  = 2'(1 << m_own);
                e_err   = mem_ready ? 2'b00 : e_done;
                e_valid = 0;
                e_rden  = 1;
                if (!mem_ready) e_rdata = 8'hFF;
                else if (!m_we) e_rdata = mem_data_in;
            end else begin
                m_age++;
            end
        end else begin
            cand = m_lockh ? (req & 2'(1 << m_last)) : req;
            if (cand != 2'b00) begin
                if (cand == 2'b11) w = m_last ? 0 : 1;
                else w = cand[1] ? 1 : 0;
                m_busy  = 1;
                m_age   = 0;
                m_own   = w;
                m_we    = req_we[w];
                m_lk    = req_lock[w];
                e_gnt   = 2'(1 << w);
                e_addr  = w ? addr1 : addr0;
                e_wd    = w ? wdata1 : wdata0;
                e_rden  = !req_we[w];
                e_valid = 1;
            end
        end
    endtask

    always @(negedge ph1) begin
        if (chk_en) begin
            n_cmp++;
            if ({gnt, done, err, rdata, mem_address, mem_data_out,
                 mem_read_en, mem_valid} !==
                {e_gnt, e_done, e_err, e_rdata, e_addr, e_wd,
                 e_rden, e_valid}) begin
                n_bad++;
                $display("FAIL model cyc=%0d got/exp gnt %b/%b done %b/%b err %b/%b rdata %h/%h addr %h/%h wd %h/%h rden %b/%b valid %b/%b",
                         cyc, gnt, e_gnt, done, e_done, err, e_err,
                         rdata, e_rdata, mem_address, e_addr,
                         mem_data_out, e_wd, mem_read_en, e_rden,
                         mem_valid, e_valid);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge ph1);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        reset = 1;
        req = 0;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic wait_grant(input string nm, output logic [1:0] g);
        int k;
        k = 0;
        while (gnt != 2'b00 && k < 40) begin cycle(); k++; end
        while (gnt == 2'b00 && k < 40) begin cycle(); k++; end
        chk({nm, "_wait"}, 32'(k < 40), 32'd1);
        g = gnt;
    endtask

    logic [1:0] g;
    int k;
    int pct;

    initial begin
        reset = 1; req = 0; req_we = 0; req_lock = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_data_in = 0; mem_ready = 0;
        cycle();
        chk_en = 1;
        reset_dut();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rden", mem_read_en, 1'b1);
        chk("rst_addr", mem_address, 16'h0000);

        // First tie goes to CPU; immediate ready read.
        req = 2'b11; addr0 = 16'h1234; addr1 = 16'hABCD;
        req_we = 2'b00; req_lock = 2'b00;
        mem_ready = 1; mem_data_in = 8'hA5;
        cycle();
        chk("first_gnt", gnt, 2'b01);
        chk("first_addr", mem_address, 16'h1234);
        chk("first_valid", mem_valid, 1'b1);
        cycle();
        chk("first_done", done, 2'b01);
        chk("first_rdata", rdata, 8'hA5);
        chk("first_valid_off", mem_valid, 1'b0);
        for (int i = 1; i < 4; i++) begin
            wait_grant("rr", g);
            chk($sformatf("rr_order%0d", i), g,
                (i % 2) ? 2'b10 : 2'b01);
        end

        // Locked CPU write keeps the bus across a DMA request.
        reset_dut();
        req = 2'b01; req_we = 2'b11; req_lock = 2'b01;
        addr0 = 16'h00FF; wdata0 = 8'h3C;
        addr1 = 16'h2000; wdata1 = 8'h77;
        mem_ready = 1;
        wait_grant("lock1", g);
        chk("lock1_gnt", g, 2'b01);
        chk("lock1_addr", mem_address, 16'h00FF);
        chk("lock1_wd", mem_data_out, 8'h3C);
        chk("lock1_rden", mem_read_en, 1'b0);
        req = 2'b11; req_lock = 2'b00;
        wait_grant("lock2", g);
        chk("lock2_cpu_again", g, 2'b01);
        wait_grant("lock3", g);
        chk("lock3_dma", g, 2'b10);
        cycle();
        chk("lock3_done", done, 2'b10);
        chk("write_keeps_rdata", rdata, 8'h00);

        // Timeout, with the requester dropping req mid-access.
        reset_dut();
        req = 2'b10; req_we = 2'b00; mem_ready = 0;
        wait_grant("to", g);
        chk("to_gnt", g, 2'b10);
        req = 2'b00;
        k = 0;
        while (done == 2'b00 && k < 40) begin cycle(); k++; end
        chk("to_latency", k, 16);
        chk("to_done", done, 2'b10);
        chk("to_err", err, 2'b10);
        chk("to_rdata", rdata, 8'hFF);

        // Ready arriving exactly on the timeout cycle.
        req = 2'b01;
        wait_grant("edge", g);
        req = 2'b00;
        repeat (15) cycle();
        mem_data_in = 8'h5A; mem_ready = 1;
        cycle();
        chk("edge_done", done, 2'b01);
        chk("edge_err", err, 2'b00);
        chk("edge_rdata", rdata, 8'h5A);
        mem_ready = 0;

        // Reset during the third access cycle.
        reset_dut();
        req = 2'b01;
        wait_grant("rmid", g);
        cycle();
        cycle();
        reset = 1;
        cycle();
        chk("rmid_gnt", gnt, 2'b00);
        chk("rmid_valid", mem_valid, 1'b0);
        chk("rmid_rden", mem_read_en, 1'b1);
        chk("rmid_done", done, 2'b00);
        reset = 0; req = 0;
        repeat (3) begin
            cycle();
            chk("rmid_no_done", done, 2'b00);
        end

        for (int i = 0; i < 4000; i++) begin
            pct = ((i / 500) % 2) ? 6 : 60;
            reset = ($urandom_range(0, 399) == 0);
            req = 2'($urandom);
            req_we = 2'($urandom);
            req_lock = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            addr0 = 16'($urandom); addr1 = 16'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            mem_data_in = 8'($urandom);
            mem_ready = ($urandom_range(0, 99) < pct);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
